// File: rtl/sokoban_pkg.sv
// Shared Sokoban definitions: grid geometry, direction encoding and the
// bit layout of the packed game state {way, box, pos}.
package sokoban_pkg;

  localparam int GRID_W  = 8;
  localparam int CELLS   = 64;
  localparam int STATE_W = 134;
  localparam int POS_W   = 6;

  // Field slices of the packed game state.
  localparam int WAY_MSB = 133;
  localparam int WAY_LSB = 70;
  localparam int BOX_MSB = 69;
  localparam int BOX_LSB = 6;
  localparam int POS_MSB = 5;
  localparam int POS_LSB = 0;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  // Outcome of classifying a move request.
  typedef enum logic [1:0] {
    ACT_REJECT = 2'd0,
    ACT_WALK   = 2'd1,
    ACT_PUSH   = 2'd2
  } act_t;

  // One undo history record: the direction moved and whether a box moved with it.
  typedef struct packed {
    dir_t dir;
    logic pushed;
  } hist_ent_t;

endpackage

// File: rtl/move_history.sv
// Bounded LIFO of undo records held in a ring buffer. A push when full
// overwrites the oldest record; a pop when empty does nothing.
module move_history #(
  parameter  int DEPTH   = 16,
  parameter  int ENTRY_W = 3,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic [CNT_W-1:0]   count
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   top_q;   // slot the next push writes
  logic [CNT_W-1:0]   count_q;
  logic [PTR_W-1:0]   rd_idx;

  // Top-of-stack pointer and occupancy; the pointer wraps, so a full buffer
  // simply overwrites its oldest slot.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // always_ff reads the pre-edge values regardless of evaluation order.
    if (reset || clear) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      top_q <= top_q + 1'b1;
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + 1'b1;
    end else if (pop && (count_q != '0)) begin
      top_q   <= top_q - 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  // Record storage.
  // NOTE: the storage array has no reset; count_q gates what is visible,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[top_q] <= din;
  end

  assign rd_idx = top_q - 1'b1;
  assign dout   = mem_q[rd_idx];
  assign count  = count_q;

endmodule

// File: rtl/move_engine.sv
// Sokoban move sequencer: owns the game state, turns a direction request into
// a walk, a push or a rejection, and retracts moves from a bounded history.
module move_engine
  import sokoban_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int STEP_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [STATE_W-1:0] init_state,
  input  logic               start,
  input  logic [1:0]         dir,
  input  logic               undo,
  output logic [STATE_W-1:0] game_state,
  output logic               state_we,
  output logic               busy,
  output logic               done,
  output logic               accepted,
  output logic               can_undo,
  output logic [STEP_W-1:0]  steps
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_COMMIT,
    S_UNPOP,
    S_UNDO
  } state_t;

  state_t             state_q;
  logic [STATE_W-1:0] game_state_q;
  logic [STEP_W-1:0]  steps_q;
  dir_t               dir_q;
  act_t               act_q;
  logic [POS_W-1:0]   t1_q;
  logic [POS_W-1:0]   t2_q;
  hist_ent_t          ent_q;
  logic               done_q;
  logic               accepted_q;
  logic               state_we_q;
  logic               busy_q;

  // True when stepping from p in direction d leaves the 8x8 grid.
  function automatic logic off_grid(input logic [POS_W-1:0] p, input dir_t d);
    case (d)
      DIR_UP:    return p[5:3] == 3'd0;
      DIR_DOWN:  return p[5:3] == 3'd7;
      DIR_LEFT:  return p[2:0] == 3'd0;
      default:   return p[2:0] == 3'd7;
    endcase
  endfunction

  // Neighbour of p in direction d (only meaningful when not off-grid).
  function automatic logic [POS_W-1:0] step_fwd(input logic [POS_W-1:0] p, input dir_t d);
    case (d)
      DIR_UP:    return p - 6'd8;
      DIR_DOWN:  return p + 6'd8;
      DIR_LEFT:  return p - 6'd1;
      default:   return p + 6'd1;
    endcase
  endfunction

  // Neighbour of p opposite to direction d.
  function automatic logic [POS_W-1:0] step_back(input logic [POS_W-1:0] p, input dir_t d);
    case (d)
      DIR_UP:    return p + 6'd8;
      DIR_DOWN:  return p - 6'd8;
      DIR_LEFT:  return p + 6'd1;
      default:   return p - 6'd1;
    endcase
  endfunction

  // History interface.
  logic             hist_clear;
  logic             hist_push;
  logic             hist_pop;
  hist_ent_t        hist_din;
  logic [2:0]       hist_dout;
  logic [CNT_W-1:0] hist_count;

  assign hist_clear = (state_q == S_IDLE) && load;
  assign hist_push  = (state_q == S_COMMIT) && (act_q != ACT_REJECT);
  assign hist_pop   = (state_q == S_UNPOP);
  assign hist_din   = '{dir: dir_q, pushed: (act_q == ACT_PUSH)};

  move_history #(
    .DEPTH   (DEPTH),
    .ENTRY_W ($bits(hist_ent_t))
  ) u_history (
    .clk   (clk),
    .reset (reset),
    .clear (hist_clear),
    .push  (hist_push),
    .pop   (hist_pop),
    .din   (hist_din),
    .dout  (hist_dout),
    .count (hist_count)
  );

  // State field views and the candidate next states for each operation.
  logic [CELLS-1:0] way_v;
  logic [CELLS-1:0] box_v;
  logic [POS_W-1:0] pos_v;
  logic [POS_W-1:0] t1_c;
  logic [POS_W-1:0] t2_c;
  logic             t1_ok;
  logic             t2_ok;
  act_t             act_c;
  logic [CELLS-1:0] commit_box;
  logic [CELLS-1:0] undo_box;
  logic [POS_W-1:0] undo_pos;
  logic [POS_W-1:0] undo_fwd;

  // Move classification and next-state box bitmaps.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    way_v      = game_state_q[WAY_MSB:WAY_LSB];
    box_v      = game_state_q[BOX_MSB:BOX_LSB];
    pos_v      = game_state_q[POS_MSB:POS_LSB];
    t1_c       = step_fwd(pos_v, dir_q);
    t1_ok      = !off_grid(pos_v, dir_q);
    t2_c       = step_fwd(t1_c, dir_q);
    t2_ok      = t1_ok && !off_grid(t1_c, dir_q);
    act_c      = ACT_REJECT;
    commit_box = box_v;
    undo_box   = box_v;
    undo_pos   = step_back(pos_v, ent_q.dir);
    undo_fwd   = step_fwd(pos_v, ent_q.dir);

    if (t1_ok && way_v[t1_c]) begin
      if (!box_v[t1_c])                              act_c = ACT_WALK;
      else if (t2_ok && way_v[t2_c] && !box_v[t2_c]) act_c = ACT_PUSH;
    end

    if (act_q == ACT_PUSH) begin
      commit_box[t1_q] = 1'b0;
      commit_box[t2_q] = 1'b1;
    end

    if (ent_q.pushed) begin
      undo_box[undo_fwd] = 1'b0;
      undo_box[pos_v]    = 1'b1;
    end
  end

  // Sequencer FSM with registered state and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      game_state_q <= '0;
      steps_q      <= '0;
      dir_q        <= DIR_UP;
      act_q        <= ACT_REJECT;
      t1_q         <= '0;
      t2_q         <= '0;
      ent_q        <= '0;
      done_q       <= 1'b0;
      accepted_q   <= 1'b0;
      state_we_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      accepted_q <= 1'b0;
      state_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load) begin
            game_state_q <= init_state;
            steps_q      <= '0;
            state_we_q   <= 1'b1;
          end else if (undo) begin
            busy_q <= 1'b1;
            if (hist_count == '0) begin
              act_q   <= ACT_REJECT;
              state_q <= S_COMMIT;
            end else begin
              state_q <= S_UNPOP;
            end
          end else if (start) begin
            dir_q   <= dir_t'(dir);
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          t1_q    <= t1_c;
          t2_q    <= t2_c;
          act_q   <= act_c;
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          if (act_q != ACT_REJECT) begin
            game_state_q <= {way_v, commit_box, t1_q};
            if (steps_q != '1) steps_q <= steps_q + 1'b1;
            accepted_q   <= 1'b1;
            state_we_q   <= 1'b1;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_UNPOP: begin
          ent_q   <= hist_ent_t'(hist_dout);
          state_q <= S_UNDO;
        end
        S_UNDO: begin
          game_state_q <= {way_v, undo_box, undo_pos};
          if (steps_q != '0) steps_q <= steps_q - 1'b1;
          done_q     <= 1'b1;
          accepted_q <= 1'b1;
          state_we_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign game_state = game_state_q;
  assign state_we   = state_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign accepted   = accepted_q;
  assign can_undo   = (hist_count != '0);
  assign steps      = steps_q;

endmodule

// File: doc/move_engine.md
# move_engine

Sequencing datapath for a Sokoban move, between the input decoder and the game-state register bank. It owns the 134-bit game state: way bitmap, box bitmap and player position. It turns a direction request into a walk, a push or a rejection. Each accepted move is recorded in a bounded undo history, so the top-level controller can retract moves without a second copy of the state.

## Interface
- DEPTH, 16: undo history entries (power of two, 2..64)
- STEP_W, 10: step counter width
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- load  in  1  latch init_state, clear history and steps
- init_state  in  134  {way[63:0], box[63:0], pos[5:0]}
- start  in  1  move request, sampled only in IDLE
- dir  in  2  0 up, 1 down, 2 left, 3 right; sampled with start
- undo  in  1  retract request, sampled only in IDLE
- game_state  out  134  current state, registered
- state_we  out  1  one-cycle pulse the cycle game_state changes from a move or undo
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse ending every accepted start/undo
- accepted  out  1  valid with done: 1 = state changed, 0 = rejected
- can_undo  out  1  history count > 0
- steps  out  STEP_W  net moves since load

## Operation
- Grid is 8x8, index = row*8+col. Deltas: up -8, down +8, left -1, right +1.
- A step from p is off-grid when:
  - up: row 0
  - down: row 7
  - left: col 0
  - right: col 7
- FSM states: IDLE, CALC, COMMIT, UNPOP, UNDO.
- IDLE:
  - load has top priority: game_state <= init_state, history count <= 0, steps <= 0. No done pulse; state_we pulses.
  - Otherwise undo has priority over start. Undo with count 0 goes to COMMIT as a rejection.
  - Undo with count > 0 goes to UNPOP.
  - start goes to CALC.
- CALC registers t1 = p+d and t2 = t1+d, with valid flags, then classifies:
  - reject: t1 off-grid, or !way[t1]
  - walk: way[t1] && !box[t1]
  - push: box[t1] && t2 valid && way[t2] && !box[t2]
  - reject: any other box[t1] case
- COMMIT:
  - Walk: pos <= t1.
  - Push: box[t1] <= 0, box[t2] <= 1, pos <= t1.
  - Accepted moves push history entry {dir, pushed} and steps +1 (saturates at all-ones). Pulse done and state_we.
  - Rejections pulse done with accepted=0 and do not pulse state_we.
  - Return to IDLE.
- UNPOP reads the top history entry; count -1.
- UNDO:
  - Compute prev = pos - d.
  - If pushed: box[pos+d] <= 0, box[pos] <= 1.
  - pos <= prev; steps -1 (floor 0).
  - Pulse done/accepted/state_we; return to IDLE.
- The way bitmap is never modified after load.
- History is a ring buffer. Push when count == DEPTH overwrites the oldest entry; count stays DEPTH.
- start/undo while busy are dropped, not queued. load while busy is also ignored; the caller issues it from IDLE.

## Timing
- Move: start in IDLE at cycle 0; CALC at cycle 1; COMMIT at cycle 2, with done, state_we and new game_state visible at cycle 3 (registered).
- Undo: UNPOP at cycle 1, UNDO at cycle 2, results visible at cycle 3.
- Rejected undo: COMMIT at cycle 1, done at cycle 2.
- busy rises the cycle after the request is sampled and falls with the done cycle. The next request is accepted the cycle after done.
- Reset values:
  - game_state = 0, steps = 0, count = 0
  - busy, done, accepted, state_we, can_undo = 0
  - FSM in IDLE
- Reset mid-operation abandons the move; no done pulse.

## Structure
- Shared package sokoban_pkg holds:
  - GRID_W = 8, CELLS = 64, STATE_W = 134, POS_W = 6
  - dir_t encoding
  - field slice offsets (way 133:70, box 69:6, pos 5:0)
- One sub-module, move_history: parameterised ring-buffer LIFO of 3-bit entries.
  - Ports: push, pop, din, dout, count, clear.
  - Overwrite-on-full; pop on empty is a no-op.
- Neighbour and edge checks are combinational functions in move_engine.

## Test plan
- Walk into open cell: load pos=9, way all 1, box 0; start dir=3 → cycle 3: pos=10, accepted=1, steps=1, can_undo=1.
- Push accepted: pos=9, box[10]=1; start dir=3 → box[10]=0, box[11]=1, pos=10. Undo → pos=9, box[10]=1, box[11]=0, steps=0, can_undo=0.
- Push blocked: box[10]=box[11]=1 → accepted=0, state_we never pulses, game_state unchanged.
- Edge rejections:
  - pos=7, dir=3 → rejected.
  - pos=0, dir=0 → rejected.
  - pos=6, box[7]=1, dir=3 → rejected (t2 off-grid).
- History overflow: 20 walks alternating left/right with DEPTH=16 → 16 undos accepted, the 17th returns accepted=0 with done at cycle 2. steps goes 20→4.
- Priority/busy: start and undo in the same IDLE cycle → undo executes. start during busy → ignored. reset asserted in CALC → all outputs 0 the next cycle.
